// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and helpers for the conv2d_stream engine:
//               FSM state encoding, a constant log2 helper and the
//               saturate/truncate decision used on accumulator results.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_IMG = 3'd1,
    ST_LOAD_KER = 3'd2,
    ST_MAC      = 3'd3,
    ST_OUT      = 3'd4
  } state_t;

  // Outcome of the saturation decision: pass low bits, clamp high, clamp low.
  typedef enum logic [1:0] {
    SAT_PASS = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } sat_sel_t;

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2_int(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // Decides how an accumulator value maps onto an out_w-bit sample.
  // acc must already be sign- or zero-extended to 64 bits by the caller.
  function automatic sat_sel_t sat_select(input logic [63:0] acc, input int out_w,
                                          input bit is_signed, input bit do_sat);
    logic signed [63:0] v;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_sel_t           sel;
    v   = $signed(acc);
    sel = SAT_PASS;
    if (is_signed) begin
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
    end else begin
      hi = (64'sd1 <<< out_w) - 64'sd1;
      lo = 64'sd0;
    end
    if (do_sat) begin
      if (v > hi)      sel = SAT_HI;
      else if (v < lo) sel = SAT_LO;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_mac.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac
// Description : Registered multiply-accumulate. On en, acc <= (first ? 0 : acc)
//               + a*b. res is the saturated/truncated view of the value being
//               written this cycle, so a window's result is ready on its last
//               product without an extra pipeline cycle.
// Ports       : clk, rst (async, high) | en, first | a, b (DATA_W) | res (OUT_W)
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac
  import conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              first,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [OUT_W-1:0]  res
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nx;
  logic [ACC_W-1:0] prod_ext;
  logic [63:0]      acc_wide;
  sat_sel_t         sel;

  generate
    if (SIGNED != 0) begin : g_signed
      logic signed [2*DATA_W-1:0] prod;
      assign prod     = $signed(a) * $signed(b);
      assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      assign acc_wide = {{(64-ACC_W){acc_nx[ACC_W-1]}}, acc_nx};
    end else begin : g_unsigned
      logic [2*DATA_W-1:0] prod;
      assign prod     = a * b;
      assign prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, prod};
      assign acc_wide = {{(64-ACC_W){1'b0}}, acc_nx};
    end
  endgenerate

  assign acc_nx = (first ? '0 : acc) + prod_ext;
  assign sel    = sat_select(acc_wide, OUT_W, SIGNED != 0, SAT != 0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     acc <= '0;
    else if (en) acc <= acc_nx;
  end

  always_comb begin
    res = acc_nx[OUT_W-1:0];
    case (sel)
      SAT_HI:  res = (SIGNED != 0) ? {1'b0, {(OUT_W-1){1'b1}}} : {OUT_W{1'b1}};
      SAT_LO:  res = (SIGNED != 0) ? {1'b1, {(OUT_W-1){1'b0}}} : {OUT_W{1'b0}};
      default: res = acc_nx[OUT_W-1:0];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/conv2d_stream.sv
`default_nettype none
// ============================================================================
// Module      : conv2d_stream
// Description : Streaming 2-D valid-mode convolution. Loads an image then a
//               kernel (raster order, valid/ready), runs one MAC per cycle
//               over every window at stride 1 or 2, then streams the output
//               map with out_last on the final sample.
// Ports       : clk, rst (async, high), start, cfg_* (latched in IDLE)
//               img_data/valid/ready, ker_data/valid/ready (sink side)
//               out_data/valid/ready/last (source side), busy, err
// Revision    : 1.0 - initial release
// ============================================================================
module conv2d_stream
  import conv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_DIM = 16,
  parameter int DIM_W   = 4,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 16,
  parameter int SIGNED  = 0,
  parameter int SAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  cfg_img_r,
  input  logic [DIM_W-1:0]  cfg_img_c,
  input  logic [DIM_W-1:0]  cfg_ker_r,
  input  logic [DIM_W-1:0]  cfg_ker_c,
  input  logic              cfg_stride,
  input  logic [DATA_W-1:0] img_data,
  input  logic              img_valid,
  output logic              img_ready,
  input  logic [DATA_W-1:0] ker_data,
  input  logic              ker_valid,
  output logic              ker_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int DEPTH  = MAX_DIM * MAX_DIM;
  localparam int ADDR_W = clog2_int(DEPTH);

  state_t            state, state_nx;
  logic [DIM_W-1:0]  img_r, img_c, ker_r, ker_c;
  logic              stride;
  logic [DIM_W-1:0]  cnt_r, cnt_c;   // load index, or kernel p/q during MAC
  logic [DIM_W-1:0]  win_r, win_c;   // output-map index during MAC and OUT
  logic [DIM_W-1:0]  lim_r, lim_c, or_m1, oc_m1, mac_r, mac_c;
  logic              cfg_bad, img_xfer, ker_xfer, out_xfer, mac_en, mac_first;
  logic              cnt_step, cnt_last, win_step, win_last;
  logic [ADDR_W-1:0] load_addr, mac_addr, win_addr;
  logic [OUT_W-1:0]  mac_res;

  logic [DATA_W-1:0] img_buf [DEPTH];
  logic [DATA_W-1:0] ker_buf [DEPTH];
  logic [OUT_W-1:0]  out_buf [DEPTH];

  assign cfg_bad  = (cfg_ker_r > cfg_img_r) || (cfg_ker_c > cfg_img_c);
  assign img_xfer = img_valid && img_ready;
  assign ker_xfer = ker_valid && ker_ready;
  assign out_xfer = out_valid && out_ready;
  assign mac_en   = (state == ST_MAC);

  // The shared counter walks the image while loading it, the kernel otherwise.
  assign lim_r    = (state == ST_LOAD_IMG) ? img_r : ker_r;
  assign lim_c    = (state == ST_LOAD_IMG) ? img_c : ker_c;
  assign cnt_last = (cnt_r == lim_r) && (cnt_c == lim_c);
  assign cnt_step = img_xfer || ker_xfer || mac_en;

  // Last output index = floor((img - ker) / S); floor division by 2 is a shift.
  assign or_m1    = (img_r - ker_r) >> stride;
  assign oc_m1    = (img_c - ker_c) >> stride;
  assign win_last = (win_r == or_m1) && (win_c == oc_m1);
  assign win_step = (mac_en && cnt_last) || out_xfer;

  assign mac_r     = (win_r << stride) + cnt_r;
  assign mac_c     = (win_c << stride) + cnt_c;
  assign mac_first = (cnt_r == '0) && (cnt_c == '0);
  assign load_addr = {cnt_r, cnt_c};
  assign mac_addr  = {mac_r, mac_c};
  assign win_addr  = {win_r, win_c};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    img_ready = 1'b0;
    ker_ready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start && !cfg_bad) state_nx = ST_LOAD_IMG;
      end
      ST_LOAD_IMG: begin
        img_ready = 1'b1;
        if (img_valid && cnt_last) state_nx = ST_LOAD_KER;
      end
      ST_LOAD_KER: begin
        ker_ready = 1'b1;
        if (ker_valid && cnt_last) state_nx = ST_MAC;
      end
      ST_MAC: begin
        if (cnt_last && win_last) state_nx = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        out_last  = win_last;
        if (out_ready && win_last) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign out_data = out_valid ? out_buf[win_addr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      img_r  <= '0;
      img_c  <= '0;
      ker_r  <= '0;
      ker_c  <= '0;
      stride <= 1'b0;
      cnt_r  <= '0;
      cnt_c  <= '0;
      win_r  <= '0;
      win_c  <= '0;
      err    <= 1'b0;
    end else begin
      err <= (state == ST_IDLE) && start && cfg_bad;
      if ((state == ST_IDLE) && start) begin
        img_r  <= cfg_img_r;
        img_c  <= cfg_img_c;
        ker_r  <= cfg_ker_r;
        ker_c  <= cfg_ker_c;
        stride <= cfg_stride;
      end
      // Both counters wrap to zero on their last index, so each phase
      // starts from the origin without an explicit clear.
      if (cnt_step) begin
        if (cnt_c == lim_c) begin
          cnt_c <= '0;
          cnt_r <= (cnt_r == lim_r) ? '0 : cnt_r + DIM_W'(1);
        end else begin
          cnt_c <= cnt_c + DIM_W'(1);
        end
      end
      if (win_step) begin
        if (win_c == oc_m1) begin
          win_c <= '0;
          win_r <= (win_r == or_m1) ? '0 : win_r + DIM_W'(1);
        end else begin
          win_c <= win_c + DIM_W'(1);
        end
      end
    end
  end

  // Buffers are plain RAMs: no reset, contents are always rewritten before use.
  always_ff @(posedge clk) begin
    if (img_xfer)            img_buf[load_addr] <= img_data;
    if (ker_xfer)            ker_buf[load_addr] <= ker_data;
    if (mac_en && cnt_last)  out_buf[win_addr]  <= mac_res;
  end

  conv_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SIGNED (SIGNED),
    .SAT    (SAT)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .en    (mac_en),
    .first (mac_first),
    .a     (img_buf[mac_addr]),
    .b     (ker_buf[load_addr]),
    .res   (mac_res)
  );

endmodule
`default_nettype wire
